// File: rtl/io_pkg.sv
// Shared types and default widths for the input-instruction responder.
// Optional feature macro: IO_SIGN_EXT_EN (sign-extend captured switches).
package io_pkg;

    localparam int DATA_W_DEF      = 10;
    localparam int OUT_W_DEF       = 32;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CLEAR,
        WAIT_PRESS,
        CAPTURED,
        WAIT_RELEASE
    } io_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with an optional per-bit rising-edge detector.
// Macro: none.
module sync_edge #(
    parameter int W       = 1,
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_chain [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic [W-1:0] r_prev;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_prev <= '0;
                end else begin
                    r_prev <= o_q;
                end
            end

            assign o_rise = o_q & ~r_prev;
        end else begin : g_no_edge
            assign o_rise = '0;
        end
    endgenerate

endmodule

// File: rtl/io_input_responder.sv
// Returns one operator-confirmed switch value per input instruction.
// Macro: IO_SIGN_EXT_EN selects sign- instead of zero-extension.
module io_input_responder
    import io_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              input_request,
    input  logic [DATA_W-1:0] switches,
    input  logic              confirm,
    output logic [OUT_W-1:0]  io_data,
    output logic              io_valid,
    output logic              waiting,
    output logic              busy
);

    logic              w_conf_sync;
    logic              w_press;
    logic [DATA_W-1:0] w_sw_sync;
    logic [DATA_W-1:0] w_sw_rise_unused;
    logic [OUT_W-1:0]  w_ext;
    logic              w_capture;

    io_state_t         r_state;
    io_state_t         w_next;
    logic [OUT_W-1:0]  r_data;

    sync_edge #(
        .W       (1),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b1)
    ) u_conf_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (confirm),
        .o_q    (w_conf_sync),
        .o_rise (w_press)
    );

    sync_edge #(
        .W       (DATA_W),
        .STAGES  (SYNC_STAGES),
        .EDGE_EN (1'b0)
    ) u_sw_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (switches),
        .o_q    (w_sw_sync),
        .o_rise (w_sw_rise_unused)
    );

`ifdef IO_SIGN_EXT_EN
    assign w_ext = OUT_W'($signed(w_sw_sync));
`else
    assign w_ext = OUT_W'(w_sw_sync);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over a same-cycle press so a dropped request never captures.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (input_request) begin
                    w_next = w_conf_sync ? WAIT_CLEAR : WAIT_PRESS;
                end
            end
            WAIT_CLEAR: begin
                if (!input_request) begin
                    w_next = IDLE;
                end else if (!w_conf_sync) begin
                    w_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!input_request) begin
                    w_next = IDLE;
                end else if (w_press) begin
                    w_next    = CAPTURED;
                    w_capture = 1'b1;
                end
            end
            CAPTURED: begin
                w_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!w_conf_sync) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_capture) begin
            r_data <= w_ext;
        end
    end

    assign io_data  = r_data;
    assign io_valid = (r_state == CAPTURED);
    assign waiting  = (r_state == WAIT_PRESS);
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_io_input_responder.sv
// Self-checking bench for io_input_responder: vector table, hand
// sequences and random traffic against a behavioural model.
module tb_io_input_responder;

    localparam int DW = 10;
    localparam int OW = 32;
    localparam int S  = 2;

`ifdef IO_SIGN_EXT_EN
    localparam logic [31:0] EXT3FF = 32'hFFFFFFFF;
`else
    localparam logic [31:0] EXT3FF = 32'h000003FF;
`endif

    logic          clk;
    logic          rst;
    logic          req;
    logic [DW-1:0] sw;
    logic          conf;
    logic [OW-1:0] io_data;
    logic          io_valid;
    logic          waiting;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [31:0] last_data = '0;

    io_input_responder #(
        .DATA_W      (DW),
        .OUT_W       (OW),
        .SYNC_STAGES (S)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .input_request (req),
        .switches      (sw),
        .confirm       (conf),
        .io_data       (io_data),
        .io_valid      (io_valid),
        .waiting       (waiting),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: inputs seen S edges late; transaction flags.
    logic [S-1:0]  mc_hist;
    logic [DW-1:0] ms_hist [S];
    logic          m_prev;
    logic          m_armed;
    logic          m_clear;
    logic          m_pulse;
    logic          m_hold;
    logic [31:0]   m_data;
    logic          m_cs;
    logic          m_press;
    logic [DW-1:0] m_sws;

    assign m_cs    = mc_hist[S-1];
    assign m_press = m_cs & ~m_prev;
    assign m_sws   = ms_hist[S-1];

    function automatic logic [31:0] ext(input logic [DW-1:0] v);
`ifdef IO_SIGN_EXT_EN
        return v[DW-1] ? (32'(v) | 32'hFFFFFC00) : 32'(v);
`else
        return 32'(v);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_hist <= '0;
            for (int i = 0; i < S; i++) ms_hist[i] <= '0;
            m_prev  <= 1'b0;
            m_armed <= 1'b0;
            m_clear <= 1'b0;
            m_pulse <= 1'b0;
            m_hold  <= 1'b0;
            m_data  <= '0;
        end else begin
            mc_hist    <= {mc_hist[S-2:0], conf};
            ms_hist[0] <= sw;
            for (int i = 1; i < S; i++) ms_hist[i] <= ms_hist[i-1];
            m_prev <= m_cs;
            if (m_pulse) begin
                m_pulse <= 1'b0;
                m_hold  <= 1'b1;
            end else if (m_hold) begin
                if (!m_cs) m_hold <= 1'b0;
            end else if (m_armed) begin
                if (!req) begin
                    m_armed <= 1'b0;
                    m_clear <= 1'b0;
                end else if (m_clear) begin
                    if (!m_cs) m_clear <= 1'b0;
                end else if (m_press) begin
                    m_data  <= ext(m_sws);
                    m_pulse <= 1'b1;
                    m_armed <= 1'b0;
                end
            end else if (req) begin
                m_armed <= 1'b1;
                m_clear <= m_cs;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic [DW-1:0] s,
                        input logic c, input bit cmp);
        req  = r;
        sw   = s;
        conf = c;
        @(posedge clk);
        #1;
        if (io_valid === 1'b1) begin
            pulses++;
            last_data = io_data;
        end
        if (cmp) begin
            chk("mdl_valid", 32'(io_valid), 32'(m_pulse));
            chk("mdl_wait", 32'(waiting), 32'(m_armed & ~m_clear));
            chk("mdl_busy", 32'(busy), 32'(m_armed | m_pulse | m_hold));
            chk("mdl_data", io_data, m_data);
        end
    endtask

    typedef struct {
        logic          r;
        logic [DW-1:0] s;
        logic          c;
        logic          ev;
        logic          ew;
        logic          eb;
        logic [31:0]   ed;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [DW-1:0] s,
                                input logic c, input logic ev,
                                input logic ew, input logic eb,
                                input logic [31:0] ed);
        vec_t v;
        v.r = r; v.s = s; v.c = c;
        v.ev = ev; v.ew = ew; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    vec_t tbl [18];

    task automatic do_reset_zero(input string nm);
        rst = 1'b1;
        #1;
        chk({nm, "_valid"}, 32'(io_valid), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_wait"}, 32'(waiting), 32'd0);
        chk({nm, "_data"}, io_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        int lat;
        bit found;
        logic rr;
        logic cc;

        tbl[0]  = mk(1, 10'h02A, 0, 0, 1, 1, 32'h0);
        tbl[1]  = mk(1, 10'h02A, 1, 0, 1, 1, 32'h0);
        tbl[2]  = mk(1, 10'h02A, 1, 0, 1, 1, 32'h0);
        tbl[3]  = mk(1, 10'h02A, 1, 1, 0, 1, 32'h2A);
        tbl[4]  = mk(1, 10'h02A, 1, 0, 0, 1, 32'h2A);
        tbl[5]  = mk(1, 10'h02A, 1, 0, 0, 1, 32'h2A);
        tbl[6]  = mk(0, 10'h02A, 0, 0, 0, 1, 32'h2A);
        tbl[7]  = mk(0, 10'h02A, 0, 0, 0, 1, 32'h2A);
        tbl[8]  = mk(0, 10'h02A, 0, 0, 0, 0, 32'h2A);
        tbl[9]  = mk(0, 10'h02A, 0, 0, 0, 0, 32'h2A);
        tbl[10] = mk(1, 10'h3FF, 0, 0, 1, 1, 32'h2A);
        tbl[11] = mk(1, 10'h3FF, 1, 0, 1, 1, 32'h2A);
        tbl[12] = mk(1, 10'h3FF, 1, 0, 1, 1, 32'h2A);
        tbl[13] = mk(1, 10'h3FF, 1, 1, 0, 1, EXT3FF);
        tbl[14] = mk(0, 10'h3FF, 0, 0, 0, 1, EXT3FF);
        tbl[15] = mk(0, 10'h3FF, 0, 0, 0, 1, EXT3FF);
        tbl[16] = mk(0, 10'h3FF, 0, 0, 0, 0, EXT3FF);
        tbl[17] = mk(0, 10'h3FF, 0, 0, 0, 0, EXT3FF);

        rst  = 1'b1;
        req  = 1'b0;
        sw   = '0;
        conf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(io_valid), 32'd0);
        chk("rst_wait", 32'(waiting), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", io_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].r, tbl[i].s, tbl[i].c, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 32'(io_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_wait", i), 32'(waiting), 32'(tbl[i].ew));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_data", i), io_data, tbl[i].ed);
        end

        // Held button: request arrives while confirm already down.
        p0 = pulses;
        repeat (3) tick(0, 10'h0, 1, 1);
        repeat (5) tick(1, 10'h0, 1, 1);
        chk("held_nopulse", 32'(pulses - p0), 32'd0);
        chk("held_wait", 32'(waiting), 32'd0);
        chk("held_busy", 32'(busy), 32'd1);
        repeat (3) tick(1, 10'h155, 0, 1);
        chk("held_rearm", 32'(waiting), 32'd1);
        repeat (4) tick(1, 10'h155, 1, 1);
        repeat (4) tick(0, 10'h155, 0, 1);
        chk("held_onepulse", 32'(pulses - p0), 32'd1);
        chk("held_data", last_data, 32'h155);

        // Abort while waiting for a press.
        p0 = pulses;
        repeat (3) tick(1, 10'h0AA, 0, 1);
        chk("abort_wait", 32'(waiting), 32'd1);
        tick(0, 10'h0AA, 0, 1);
        chk("abort_idle", 32'(busy), 32'd0);
        repeat (4) tick(0, 10'h0AA, 1, 1);
        repeat (3) tick(0, 10'h0AA, 0, 1);
        chk("abort_nopulse", 32'(pulses - p0), 32'd0);
        chk("abort_data", io_data, 32'h155);
        chk("abort_busy", 32'(busy), 32'd0);

        // Reset while the valid pulse is up.
        tick(1, 10'h1AB, 0, 1);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick(1, 10'h1AB, 1, 1);
            if (io_valid === 1'b1) found = 1'b1;
        end
        chk("rcap_found", 32'(found), 32'd1);
        do_reset_zero("rcap");
        p0 = pulses;
        repeat (3) tick(0, 10'h1AB, 1, 1);
        repeat (4) tick(0, 10'h1AB, 0, 1);
        chk("rcap_nopulse", 32'(pulses - p0), 32'd0);

        // Reset while waiting for release.
        tick(1, 10'h0F0, 0, 1);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick(1, 10'h0F0, 1, 1);
            if (io_valid === 1'b1) found = 1'b1;
        end
        chk("rrel_found", 32'(found), 32'd1);
        tick(1, 10'h0F0, 1, 1);
        chk("rrel_busy", 32'(busy), 32'd1);
        do_reset_zero("rrel");
        p0 = pulses;
        repeat (3) tick(0, 10'h0F0, 1, 1);
        repeat (4) tick(0, 10'h0F0, 0, 1);
        chk("rrel_nopulse", 32'(pulses - p0), 32'd0);

        // Back-to-back requests, latency measured from the press.
        p0 = pulses;
        for (int n = 1; n <= 2; n++) begin
            repeat (2) tick(1, DW'(n), 0, 1);
            lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                tick(1, DW'(n), 1, 1);
                if (io_valid === 1'b1) lat = k;
            end
            chk($sformatf("b2b%0d_lat", n), 32'(lat), 32'(S + 1));
            chk($sformatf("b2b%0d_data", n), last_data, 32'(n));
            tick(0, DW'(n), 1, 1);
            repeat (4) tick(0, DW'(n), 0, 1);
        end
        chk("b2b_pulses", 32'(pulses - p0), 32'd2);

        // Random traffic against the model.
        rr = 1'b0;
        cc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) rr = ~rr;
            if ($urandom_range(0, 3) == 0) cc = ~cc;
            tick(rr, DW'($urandom), cc, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
